// File: rtl/mem_arb2.sv
// Two-master to one-slave memory arbiter with combinational pass-through and an ordered
// owner FIFO that routes in-order read responses back to the master that issued them.
module mem_arb2 #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clock,
    input  logic        rst,

    output logic        m0_waitrequest,
    input  logic [1:0]  m0_id,
    input  logic [29:0] m0_address,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_writedata,
    input  logic [3:0]  m0_writedatamask,
    output logic [31:0] m0_readdata,
    output logic [1:0]  m0_readdataid,

    output logic        m1_waitrequest,
    input  logic [1:0]  m1_id,
    input  logic [29:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_writedata,
    input  logic [3:0]  m1_writedatamask,
    output logic [31:0] m1_readdata,
    output logic [1:0]  m1_readdataid,

    input  logic        s_waitrequest,
    output logic [1:0]  s_id,
    output logic [29:0] s_address,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_writedata,
    output logic [3:0]  s_writedatamask,
    input  logic [31:0] s_readdata,
    input  logic [1:0]  s_readdataid
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] CntFull = CW'(DEPTH);
    localparam logic [CW-1:0] CntOne  = CW'(1);
    localparam logic [PW-1:0] PtrOne  = PW'(1);

    // Arbitration state
    logic last_q, last_d;
    logic hold_q, hold_d;
    logic held_q, held_d;

    // Owner FIFO state
    logic [DEPTH-1:0] owner_q, owner_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             err_q, err_d;

    logic req0, req1;
    logic gnt_vld, gnt_idx;
    logic g_read, g_write;
    logic fifo_full, fifo_empty;
    logic issued, accept;
    logic push, pop;
    logic resp_vld, head_owner, route_ok;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 1'b0;
        if (hold_q) begin
            gnt_vld = 1'b1;
            gnt_idx = held_q;
        end else if (req0 && !req1) begin
            gnt_vld = 1'b1;
            gnt_idx = 1'b0;
        end else if (req1 && !req0) begin
            gnt_vld = 1'b1;
            gnt_idx = 1'b1;
        end else if (req0 && req1) begin
            gnt_vld = 1'b1;
            gnt_idx = ~last_q;
        end
    end

    always_comb begin
        if (gnt_idx) begin
            g_read          = m1_read;
            g_write         = m1_write;
            s_id            = m1_id;
            s_address       = m1_address;
            s_writedata     = m1_writedata;
            s_writedatamask = m1_writedatamask;
        end else begin
            g_read          = m0_read;
            g_write         = m0_write;
            s_id            = m0_id;
            s_address       = m0_address;
            s_writedata     = m0_writedata;
            s_writedatamask = m0_writedatamask;
        end
    end

    assign fifo_full  = (count_q == CntFull);
    assign fifo_empty = (count_q == '0);

    // Full check uses the registered count, so a same-cycle pop never unblocks a read.
    assign s_read  = gnt_vld & g_read & ~fifo_full & ~rst;
    assign s_write = gnt_vld & g_write & ~rst;
    assign issued  = s_read | s_write;
    assign accept  = issued & ~s_waitrequest;

    assign m0_waitrequest = ~(accept & ~gnt_idx);
    assign m1_waitrequest = ~(accept & gnt_idx);

    assign resp_vld   = (s_readdataid != 2'b00);
    assign head_owner = owner_q[head_q];
    assign pop        = resp_vld & ~fifo_empty;
    assign push       = accept & s_read;
    assign route_ok   = pop & ~rst;

    assign m0_readdata   = s_readdata;
    assign m1_readdata   = s_readdata;
    assign m0_readdataid = (route_ok && !head_owner) ? s_readdataid : 2'b00;
    assign m1_readdataid = (route_ok &&  head_owner) ? s_readdataid : 2'b00;

    always_comb begin
        last_d = last_q;
        hold_d = hold_q;
        held_d = held_q;
        if (accept) begin
            last_d = gnt_idx;
            hold_d = 1'b0;
        end else if (issued) begin
            // Slave stalled an issued transfer: lock the grant until it is accepted.
            hold_d = 1'b1;
            held_d = gnt_idx;
        end
    end

    always_comb begin
        owner_d = owner_q;
        tail_d  = tail_q;
        head_d  = head_q;
        count_d = count_q;
        if (push) begin
            owner_d[tail_q] = gnt_idx;
            tail_d          = tail_q + PtrOne;
        end
        if (pop) begin
            head_d = head_q + PtrOne;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
        err_d = err_q | (resp_vld & fifo_empty);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            last_q  <= 1'b1;
            hold_q  <= 1'b0;
            held_q  <= 1'b0;
            owner_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            last_q  <= last_d;
            hold_q  <= hold_d;
            held_q  <= held_d;
            owner_q <= owner_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_arb2.sv
// Directed self-checking bench for mem_arb2: arbitration, hold, FIFO full/wrap,
// response routing, orphan-response error flag and reset behaviour.
module tb_mem_arb2;

    logic        clock = 1'b0;
    logic        rst;
    logic        m0_waitrequest, m1_waitrequest;
    logic [1:0]  m0_id, m1_id;
    logic [29:0] m0_address, m1_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic [3:0]  m0_writedatamask, m1_writedatamask;
    logic [31:0] m0_readdata, m1_readdata;
    logic [1:0]  m0_readdataid, m1_readdataid;
    logic        s_waitrequest;
    logic [1:0]  s_id;
    logic [29:0] s_address;
    logic        s_read, s_write;
    logic [31:0] s_writedata;
    logic [3:0]  s_writedatamask;
    logic [31:0] s_readdata;
    logic [1:0]  s_readdataid;

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_q[$];

    mem_arb2 #(.DEPTH(4)) dut (
        .clock            (clock),
        .rst              (rst),
        .m0_waitrequest   (m0_waitrequest),
        .m0_id            (m0_id),
        .m0_address       (m0_address),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_writedatamask (m0_writedatamask),
        .m0_readdata      (m0_readdata),
        .m0_readdataid    (m0_readdataid),
        .m1_waitrequest   (m1_waitrequest),
        .m1_id            (m1_id),
        .m1_address       (m1_address),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_writedatamask (m1_writedatamask),
        .m1_readdata      (m1_readdata),
        .m1_readdataid    (m1_readdataid),
        .s_waitrequest    (s_waitrequest),
        .s_id             (s_id),
        .s_address        (s_address),
        .s_read           (s_read),
        .s_write          (s_write),
        .s_writedata      (s_writedata),
        .s_writedatamask  (s_writedatamask),
        .s_readdata       (s_readdata),
        .s_readdataid     (s_readdataid)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk_route(input string tag, input bit owner, input logic [1:0] id);
        chk({tag, "_m0id"}, {30'd0, m0_readdataid}, owner ? 32'd0 : {30'd0, id});
        chk({tag, "_m1id"}, {30'd0, m1_readdataid}, owner ? {30'd0, id} : 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        m0_id = 2'd0; m0_address = '0; m0_read = 1'b1; m0_write = 1'b0;
        m0_writedata = '0; m0_writedatamask = '0;
        m1_id = 2'd0; m1_address = '0; m1_read = 1'b0; m1_write = 1'b1;
        m1_writedata = '0; m1_writedatamask = '0;
        s_waitrequest = 1'b0; s_readdata = '0; s_readdataid = 2'd1;

        // Outputs forced during reset regardless of inputs
        settle();
        chk("rst_m0wait", m0_waitrequest, 1);
        chk("rst_m1wait", m1_waitrequest, 1);
        chk("rst_sread", s_read, 0);
        chk("rst_swrite", s_write, 0);
        chk("rst_m0rdid", m0_readdataid, 0);
        chk("rst_m1rdid", m1_readdataid, 0);
        tick();
        chk("rst_count", dut.count_q, 0);
        chk("rst_err", dut.err_q, 0);
        rst = 1'b0; m0_read = 1'b0; m1_write = 1'b0; s_readdataid = 2'd0;
        settle();
        chk("idle_sread", s_read, 0);
        chk("idle_swrite", s_write, 0);
        chk("idle_m0wait", m0_waitrequest, 1);
        chk("idle_m1wait", m1_waitrequest, 1);
        tick();

        // Simultaneous reads after reset: m0 first, then m1
        m0_read = 1'b1; m0_id = 2'd1; m0_address = 30'h10;
        m1_read = 1'b1; m1_id = 2'd2; m1_address = 30'h20;
        settle();
        chk("c1_sread", s_read, 1);
        chk("c1_saddr", s_address, 30'h10);
        chk("c1_sid", s_id, 1);
        chk("c1_m0wait", m0_waitrequest, 0);
        chk("c1_m1wait", m1_waitrequest, 1);
        tick();
        m0_read = 1'b0;
        settle();
        chk("c2_saddr", s_address, 30'h20);
        chk("c2_m1wait", m1_waitrequest, 0);
        chk("c2_m0wait", m0_waitrequest, 1);
        tick();
        m1_read = 1'b0;
        chk("c2_count", dut.count_q, 2);
        s_readdataid = 2'd1; s_readdata = 32'hAAAA0001;
        settle();
        chk_route("r1", 1'b0, 2'd1);
        chk("r1_data", m0_readdata, 32'hAAAA0001);
        tick();
        s_readdataid = 2'd2; s_readdata = 32'hBBBB0002;
        settle();
        chk_route("r2", 1'b1, 2'd2);
        chk("r2_data", m1_readdata, 32'hBBBB0002);
        tick();
        s_readdataid = 2'd0;
        chk("r2_count", dut.count_q, 0);

        // m0 write first so m1 wins the next contention
        m0_write = 1'b1; m0_address = 30'h40; m0_writedata = 32'h1; m0_writedatamask = 4'h1;
        settle();
        chk("w0_m0wait", m0_waitrequest, 0);
        tick();
        m0_write = 1'b0;
        m1_write = 1'b1; m1_id = 2'd3; m1_address = 30'h100;
        m1_writedata = 32'hDEADBEEF; m1_writedatamask = 4'hF;
        m0_read = 1'b1; m0_id = 2'd1; m0_address = 30'h44;
        s_waitrequest = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("hold_swrite", s_write, 1);
            chk("hold_sread", s_read, 0);
            chk("hold_saddr", s_address, 30'h100);
            chk("hold_sdata", s_writedata, 32'hDEADBEEF);
            chk("hold_m0wait", m0_waitrequest, 1);
            chk("hold_m1wait", m1_waitrequest, 1);
            tick();
        end
        s_waitrequest = 1'b0;
        settle();
        chk("acc4_swrite", s_write, 1);
        chk("acc4_saddr", s_address, 30'h100);
        chk("acc4_smask", s_writedatamask, 4'hF);
        chk("acc4_sid", s_id, 3);
        chk("acc4_m1wait", m1_waitrequest, 0);
        chk("acc4_m0wait", m0_waitrequest, 1);
        tick();
        m1_write = 1'b0;
        settle();
        chk("after_saddr", s_address, 30'h44);
        chk("after_m0wait", m0_waitrequest, 0);
        tick();
        m0_read = 1'b0; s_readdataid = 2'd1;
        settle();
        chk_route("r3", 1'b0, 2'd1);
        tick();
        s_readdataid = 2'd0;
        chk("r3_count", dut.count_q, 0);

        // FIFO full: fifth read stalls until a response has been registered
        m0_read = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m0_address = 30'h200 + 30'(i);
            settle();
            chk("fill_m0wait", m0_waitrequest, 0);
            tick();
        end
        m0_address = 30'h204;
        chk("full_count", dut.count_q, 4);
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("full_sread", s_read, 0);
            chk("full_m0wait", m0_waitrequest, 1);
            tick();
        end
        s_readdataid = 2'd1;
        settle();
        chk("pop_sread", s_read, 0);
        chk("pop_m0wait", m0_waitrequest, 1);
        chk_route("pop", 1'b0, 2'd1);
        tick();
        s_readdataid = 2'd0;
        settle();
        chk("unblk_sread", s_read, 1);
        chk("unblk_saddr", s_address, 30'h204);
        chk("unblk_m0wait", m0_waitrequest, 0);
        tick();
        m0_read = 1'b0;
        chk("unblk_count", dut.count_q, 4);
        for (int i = 0; i < 4; i++) begin
            s_readdataid = 2'd2;
            settle();
            chk_route("drain", 1'b0, 2'd2);
            tick();
        end
        s_readdataid = 2'd0;
        chk("drain_count", dut.count_q, 0);

        // Concurrent push/pop at count 2 with mixed owners and pointer wrap
        m0_read = 1'b1; m0_address = 30'h300;
        settle();
        chk("pp0_m0wait", m0_waitrequest, 0);
        tick();
        m0_read = 1'b0; m1_read = 1'b1; m1_address = 30'h301;
        settle();
        chk("pp1_m1wait", m1_waitrequest, 0);
        tick();
        m1_read = 1'b0;
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        chk("pp_count", dut.count_q, 2);
        for (int i = 0; i < 10; i++) begin
            bit who;
            logic [1:0] id;
            who = (i % 3 == 1) ? 1'b0 : 1'b1;
            id = 2'((i % 3) + 1);
            m0_read = ~who; m1_read = who;
            m0_address = 30'h400 + 30'(i); m1_address = 30'h500 + 30'(i);
            s_readdataid = id;
            settle();
            chk_route("pp", exp_q[0], id);
            chk("pp_wait", who ? m1_waitrequest : m0_waitrequest, 0);
            tick();
            void'(exp_q.pop_front());
            exp_q.push_back(who);
            chk("pp_cnt", dut.count_q, 2);
        end
        m0_read = 1'b0; m1_read = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_readdataid = 2'd3;
            settle();
            chk_route("ppd", exp_q[0], 2'd3);
            tick();
            void'(exp_q.pop_front());
        end
        s_readdataid = 2'd0;
        chk("ppd_count", dut.count_q, 0);

        // Orphan response on empty FIFO
        s_readdataid = 2'd3;
        settle();
        chk_route("orph", 1'b0, 2'd0);
        tick();
        s_readdataid = 2'd0;
        chk("orph_err", dut.err_q, 1);
        chk("orph_count", dut.count_q, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("orph_errclr", dut.err_q, 0);

        // Reset with two reads outstanding
        m0_read = 1'b1; m0_address = 30'h600;
        settle();
        chk("mr0_m0wait", m0_waitrequest, 0);
        tick();
        m0_read = 1'b0; m1_read = 1'b1; m1_address = 30'h601;
        settle();
        chk("mr1_m1wait", m1_waitrequest, 0);
        tick();
        m1_read = 1'b0;
        chk("mr_count", dut.count_q, 2);
        rst = 1'b1; m0_read = 1'b1; m1_write = 1'b1;
        settle();
        chk("mr_m0wait", m0_waitrequest, 1);
        chk("mr_m1wait", m1_waitrequest, 1);
        chk("mr_sread", s_read, 0);
        chk("mr_swrite", s_write, 0);
        tick();
        chk("mr_count0", dut.count_q, 0);
        rst = 1'b0; m0_read = 1'b0; m1_write = 1'b0;
        s_readdataid = 2'd1;
        settle();
        chk_route("mrlate", 1'b0, 2'd0);
        tick();
        s_readdataid = 2'd0;
        chk("mrlate_err", dut.err_q, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
